// File: rtl/key_debounce_pulse.sv
// Pushbutton synchroniser, debouncer and press/release pulse generator.
// Optional auto-repeat of press_pulse while held: define KEY_AUTOREPEAT_EN.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Elaboration-time sanity check on the configuration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_debounce_pulse: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             s1, s;
  logic             p;
  logic             level_d, press_d, release_d;
  logic             repeat_fire;

  assign p = btn ^ BTN_ACTIVE_LOW;

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1            <= 1'b0;
      s             <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= p;
      s             <= s1;
      state         <= state_d;
      cnt           <= cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d | repeat_fire;
      release_pulse <= release_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W   = $clog2(RC_MAX + 1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic [RC_W-1:0] rc, rc_d;
  logic            repeating, repeating_d;

  // rc runs only while held and stable; it freezes during a release bounce.
  always_comb begin
    rc_d        = rc;
    repeating_d = repeating;
    repeat_fire = 1'b0;
    if (state == IDLE) begin
      rc_d        = '0;
      repeating_d = 1'b0;
    end else if (state == HELD && s) begin
      if (rc == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
        rc_d        = '0;
        repeating_d = 1'b1;
        repeat_fire = 1'b1;
      end else begin
        rc_d = rc + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rc        <= '0;
      repeating <= 1'b0;
    end else begin
      rc        <= rc_d;
      repeating <= repeating_d;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse against a run-length reference model.
module tb_key_debounce_pulse;

  localparam int unsigned N  = 4;
  localparam bit          AL = 1'b1;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b1;
  logic btn_level, press_pulse, release_pulse;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(N),
    .BTN_ACTIVE_LOW (AL),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: two-sample delay, then a run of N+1 samples opposite the level flips it.
  bit m_p1, m_p2, m_level, m_press, m_rel;
  int m_run, m_hc;

  logic [2:0] got, exp_o;

  task automatic tick(input bit pressed, input bit rst_v);
    bit s_old;
    btn = AL ? !pressed : pressed;
    rst = rst_v;
    @(posedge clk);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (!rst_v) begin
      m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0; m_hc = 0;
    end else begin
      s_old = m_p2;
      if (s_old != m_level) begin
        m_run++;
        if (m_run == int'(N) + 1) begin
          m_level = s_old;
          m_run   = 0;
          if (s_old) m_press = 1'b1;
          else begin
            m_rel = 1'b1;
            m_hc  = 0;
          end
        end
      end else begin
`ifdef KEY_AUTOREPEAT_EN
        if (m_level && m_run == 0) begin
          m_hc++;
          if (m_hc >= int'(RD) && ((m_hc - int'(RD)) % int'(RP)) == 0) m_press = 1'b1;
        end
`endif
        m_run = 0;
      end
      m_p2 = m_p1;
      m_p1 = pressed;
    end
    #1;
    cyc++;
    got   = {btn_level, press_pulse, release_pulse};
    exp_o = {m_level, m_press, m_rel};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0);
      n_cmp++;
      if (got !== 3'b000) begin
        n_err++;
        $display("FAIL reset_outputs edge=%0d got=%b exp=000", i, got);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL reset_idle edge=%0d got=%b exp=%b", i, got, exp_o);
      end
    end
  endtask

  task automatic test_press_latency();
    int first = -1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1);
      if (press_pulse === 1'b1 && first < 0) first = cyc;
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL press_stable edge=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (first != int'(N) + 3) begin
      n_err++;
      $display("FAIL press_latency got=%0d exp=%0d", first, N + 3);
    end
    first = -1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1);
      if (release_pulse === 1'b1 && first < 0) first = cyc;
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL release_stable edge=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (first != int'(N) + 3 || btn_level !== 1'b0) begin
      n_err++;
      $display("FAIL release_latency got=%0d level=%b exp=%0d level=0", first, btn_level, N + 3);
    end
  endtask

  task automatic test_threshold();
    int presses = 0;
    int first   = -1;
    for (int i = 0; i < 14; i++) begin
      tick(i < 4, 1'b1);
      if (press_pulse === 1'b1) presses++;
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL short_glitch step=%0d got=%b exp=%b", i, got, exp_o);
      end
    end
    n_cmp++;
    if (presses != 0 || btn_level !== 1'b0) begin
      n_err++;
      $display("FAIL short_glitch_pulses got=%0d level=%b exp=0 level=0", presses, btn_level);
    end
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 5, 1'b1);
      if (press_pulse === 1'b1 && first < 0) first = cyc;
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL min_press step=%0d got=%b exp=%b", i, got, exp_o);
      end
    end
    n_cmp++;
    if (first != int'(N) + 3) begin
      n_err++;
      $display("FAIL min_press_edge got=%0d exp=%0d", first, N + 3);
    end
  endtask

  task automatic test_bounce_release();
    int rels = 0;
    bit pat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick(i < 4 ? pat[i] : 1'b0, 1'b1);
      if (release_pulse === 1'b1) rels++;
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL bounce_release step=%0d got=%b exp=%b", i, got, exp_o);
      end
    end
    n_cmp++;
    if (rels != 1 || btn_level !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_release_count got=%0d level=%b exp=1 level=0", rels, btn_level);
    end
  endtask

  task automatic test_reset_mid();
    int presses = 0;
    int first   = -1;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    n_cmp++;
    if (got !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_outputs got=%b exp=000", got);
    end
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b1);
      if (press_pulse === 1'b1) begin
        presses++;
        if (first < 0) first = cyc;
      end
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL reset_mid_hold edge=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
`ifndef KEY_AUTOREPEAT_EN
    n_cmp++;
    if (presses != 1 || first != int'(N) + 3) begin
      n_err++;
      $display("FAIL reset_mid_pulses got=%0d@%0d exp=1@%0d", presses, first, N + 3);
    end
`endif
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
  endtask

`ifdef KEY_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int presses = 0;
    int edges[$];
    cyc = 0;
    for (int i = 0; i < int'(N) + 3 + 30; i++) begin
      tick(1'b1, 1'b1);
      if (press_pulse === 1'b1) begin
        presses++;
        edges.push_back(cyc);
      end
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL autorepeat_hold edge=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (presses != 8 || edges.size() < 3 || edges[1] != int'(N + 3 + RD) ||
        edges[2] != int'(N + 3 + RD + RP)) begin
      n_err++;
      $display("FAIL autorepeat_count got=%0d exp=8 (first repeat at %0d)", presses, N + 3 + RD);
    end
    presses = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1);
      if (press_pulse === 1'b1) presses++;
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL autorepeat_release step=%0d got=%b exp=%b", i, got, exp_o);
      end
    end
    n_cmp++;
    if (presses != 0) begin
      n_err++;
      $display("FAIL autorepeat_after_release got=%0d exp=0", presses);
    end
  endtask
`endif

  task automatic test_random();
    bit pr = 1'b0;
    int left = 0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin
        pr   = 1'($urandom_range(0, 1));
        left = int'($urandom_range(1, 9));
      end
      left--;
      tick(pr, ($urandom_range(0, 99) != 0));
      n_cmp++;
      if (got !== exp_o || (press_pulse === 1'b1 && release_pulse === 1'b1)) begin
        n_err++;
        $display("FAIL random step=%0d got=%b exp=%b", i, got, exp_o);
      end
    end
  endtask

  initial begin
    m_p1 = 0; m_p2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_run = 0; m_hc = 0;
    test_reset();
    test_press_latency();
    test_threshold();
    test_bounce_release();
    test_reset_mid();
`ifdef KEY_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
